// File: rtl/idct_pkg.sv
// Shared constants, bank-state type and lane helper for the IDCT transpose buffer.
package idct_pkg;

  localparam int unsigned DW = 25;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = $clog2(N);
  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  function automatic logic [DW-1:0] lane(input logic [N*DW-1:0] vec, input int unsigned k);
    return vec[k*DW +: DW];
  endfunction

endpackage

// File: rtl/idct_transpose_buf_if.sv
// Column-in / row-out stream bundle between the first- and second-pass IDCT arrays.
interface idct_transpose_buf_if;
  import idct_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [N*DW-1:0] in_col;
  logic          out_valid;
  logic          out_ready;
  logic [N*DW-1:0] out_row;
  logic          out_eob;
  logic          err_sync;

  modport master (
    output in_valid, in_sof, in_col, out_ready,
    input  in_ready, out_valid, out_row, out_eob, err_sync
  );

  modport slave (
    input  in_valid, in_sof, in_col, out_ready,
    output in_ready, out_valid, out_row, out_eob, err_sync
  );

endinterface

// File: rtl/idct_tbuf_bank.sv
// One N x N coefficient bank: writes a whole column per beat, reads a whole row.
module idct_tbuf_bank
  import idct_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wcol,
  input  logic [N*DW-1:0] wdata,
  input  logic [AW-1:0]   rrow,
  output logic [N*DW-1:0] rdata
);

  // mem[row][col]; contents need no reset
  logic [DW-1:0] mem [N][N];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < N; k++) begin
        mem[k][wcol] <= lane(wdata, k);
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int j = 0; j < N; j++) begin
      rdata[j*DW +: DW] = mem[rrow][j];
    end
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong transpose buffer: fills one bank column by column while the other drains
// row by row through a registered output stage.
module idct_transpose_buf
  import idct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  idct_transpose_buf_if.slave  bus
);

  bank_st_e        st_q [2];
  logic            alive_q;
  logic            wb_q;
  logic            rb_q;
  logic [AW-1:0]   col_q;
  logic [AW-1:0]   row_q;
  logic            out_valid_q;
  logic            out_eob_q;
  logic            err_q;
  logic [N*DW-1:0] out_row_q;

  logic            eob_acc;
  logic            wr_ok;
  logic            in_acc;
  logic            we;
  logic            rb_eff;
  logic            ld;
  bank_st_e        st_eff;
  logic [AW-1:0]   wcol;
  logic [AW-1:0]   ridx;
  logic [N*DW-1:0] rdata0;
  logic [N*DW-1:0] rdata1;
  logic [N*DW-1:0] rdata;

  always_comb begin
    eob_acc = out_valid_q && bus.out_ready && out_eob_q;
    // A bank whose last row is being accepted may take a new column on the same edge
    wr_ok   = (st_q[wb_q] == EMPTY) || (st_q[wb_q] == FILLING) ||
              (eob_acc && (rb_q == wb_q));
    in_acc  = bus.in_valid && alive_q && wr_ok;
    we      = in_acc && (bus.in_sof || (col_q != '0));
    wcol    = bus.in_sof ? '0 : col_q;
    // Read side looks past a bank that retires this edge so rows stay back to back
    rb_eff  = rb_q ^ eob_acc;
    st_eff  = st_q[rb_eff];
    ld      = (!out_valid_q || bus.out_ready) && ((st_eff == FULL) || (st_eff == DRAINING));
    ridx    = (st_eff == FULL) ? '0 : row_q;
    rdata   = rb_eff ? rdata1 : rdata0;
  end

  assign bus.in_ready  = alive_q && wr_ok;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_eob   = out_eob_q;
  assign bus.err_sync  = err_q;

  idct_tbuf_bank u_bank0 (
    .clk   (clk),
    .we    (we && !wb_q),
    .wcol  (wcol),
    .wdata (bus.in_col),
    .rrow  (ridx),
    .rdata (rdata0)
  );

  idct_tbuf_bank u_bank1 (
    .clk   (clk),
    .we    (we && wb_q),
    .wcol  (wcol),
    .wdata (bus.in_col),
    .rrow  (ridx),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      alive_q     <= 1'b0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_eob_q   <= 1'b0;
      err_q       <= 1'b0;
      out_row_q   <= '0;
    end else begin
      alive_q <= 1'b1;
      err_q   <= 1'b0;

      if (eob_acc) begin
        st_q[rb_q] <= EMPTY;
        rb_q       <= ~rb_q;
      end

      if (ld) begin
        out_row_q   <= rdata;
        out_eob_q   <= (ridx == LastIdx);
        out_valid_q <= 1'b1;
        row_q       <= ridx + AW'(1);
        if (st_eff == FULL) begin
          st_q[rb_eff] <= DRAINING;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_eob_q   <= 1'b0;
      end

      // Write side comes last so a bank retired above can restart filling at once
      if (in_acc) begin
        if (bus.in_sof) begin
          err_q      <= (col_q != '0);
          col_q      <= AW'(1);
          st_q[wb_q] <= FILLING;
        end else if (col_q == '0) begin
          err_q <= 1'b1;
        end else if (col_q == LastIdx) begin
          st_q[wb_q] <= FULL;
          wb_q       <= ~wb_q;
          col_q      <= '0;
        end else begin
          col_q <= col_q + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Directed-plus-random bench: a transpose scoreboard predicts every row, eob and err pulse.
module tb_idct_transpose_buf;
  import idct_pkg::*;

  typedef struct {
    logic [N*DW-1:0] row;
    logic            eob;
  } row_t;

  logic clk;
  logic reset;

  idct_transpose_buf_if bus ();

  idct_transpose_buf u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  row_t            exp_q [$];
  logic [DW-1:0]   blk [N][N];
  int              mcol = 0;
  bit              err_exp = 0;
  bit              stall_prev = 0;
  logic [N*DW-1:0] stall_row;
  logic            stall_eob;
  int              cyc = 0, rows_seen = 0, errs_seen = 0;
  int              t_first = 0, t_last = 0, t_mark = 0;
  bit              acc_snap, ov_snap, ir_snap;
  logic [N*DW-1:0] or_snap;
  bit              rand_ready = 0;

  task automatic check(input string tag, input logic [N*DW-1:0] obs,
                       input logic [N*DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: collect columns of the current block, emit the transpose when complete
  task automatic model_in(input logic sof, input logic [N*DW-1:0] col);
    row_t e;
    if (sof) begin
      if (mcol != 0) err_exp = 1;
      mcol = 0;
    end else if (mcol == 0) begin
      err_exp = 1;
      return;
    end
    for (int k = 0; k < N; k++) blk[k][mcol] = col[k*DW +: DW];
    mcol++;
    if (mcol == N) begin
      for (int r = 0; r < N; r++) begin
        for (int j = 0; j < N; j++) e.row[j*DW +: DW] = blk[r][j];
        e.eob = (r == N - 1);
        exp_q.push_back(e);
      end
      mcol = 0;
    end
  endtask

  task automatic tick();
    row_t e;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc++;
    ov_snap  = bus.out_valid;
    ir_snap  = bus.in_ready;
    or_snap  = bus.out_row;
    acc_snap = bus.in_valid && bus.in_ready;
    check("err_sync", bus.err_sync, err_exp);
    err_exp = 0;
    if (bus.err_sync) errs_seen++;
    if (stall_prev) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_row", bus.out_row, stall_row);
      check("stall_eob", bus.out_eob, stall_eob);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_row", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("row", bus.out_row, e.row);
        check("eob", bus.out_eob, e.eob);
        if (rows_seen == t_mark) t_first = cyc;
        t_last = cyc;
        rows_seen++;
      end
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_row  = bus.out_row;
    stall_eob  = bus.out_eob;
    if (acc_snap) model_in(bus.in_sof, bus.in_col);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] make_col(input int kind, input int c);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) begin
      if (kind == 0)                 v[k*DW +: DW] = DW'(100 * k + c);
      else if (kind == 2 && k == 0)  v[k*DW +: DW] = '1;
      else if (kind == 2 && k == 1)  v[k*DW +: DW] = DW'(1) << (DW - 1);
      else                           v[k*DW +: DW] = DW'($urandom);
    end
    return v;
  endfunction

  task automatic send_col(input logic sof, input logic [N*DW-1:0] col, output int tries);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_col   = col;
    tries = 0;
    do begin
      tick();
      tries++;
    end while (!acc_snap && tries < 100);
    if (!acc_snap) check("in_timeout", acc_snap, 1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_block(input int kind, output int max_tries);
    int t;
    max_tries = 0;
    for (int c = 0; c < N; c++) begin
      send_col(c == 0, make_col(kind, c), t);
      if (t > max_tries) max_tries = t;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int tr;
    int emark;
    int n;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_col    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_eob", bus.out_eob, 0);
    check("rst_err_sync", bus.err_sync, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_in_ready_early", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready", bus.in_ready, 1);

    // Single patterned block, latency check
    bus.out_ready = 1'b1;
    send_block(0, tr);
    tick();
    check("lat_early", ov_snap, 0);
    tick();
    check("lat_first", ov_snap, 1);
    drain();

    // Three back-to-back blocks, including extreme signed values
    t_mark = rows_seen;
    send_block(2, tr);
    send_block(1, tr);
    check("b2b_ready_blk2", tr, 1);
    send_block(1, tr);
    check("b2b_ready_blk3", tr, 1);
    drain();
    check("b2b_rows", rows_seen - t_mark, 24);
    check("b2b_contig", t_last - t_first, 23);

    // Downstream stalled while two blocks arrive
    bus.out_ready = 1'b0;
    send_block(1, tr);
    send_block(1, tr);
    check("stall_fill_ready", tr, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_in_ready", ir_snap, 0);
      check("hold_valid", ov_snap, 1);
      check("hold_row0", or_snap, exp_q[0].row);
    end
    bus.out_ready = 1'b1;
    drain();

    // in_sof on the fourth column restarts the block
    emark = errs_seen;
    for (int c = 0; c < 3; c++) send_col(c == 0, make_col(1, c), tr);
    send_block(1, tr);
    drain();
    check("sof_err_once", errs_seen - emark, 1);

    // Reset mid-drain at row 3
    t_mark = rows_seen;
    send_block(1, tr);
    n = 0;
    while (rows_seen < t_mark + 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid_rows", rows_seen - t_mark, 3);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mcol       = 0;
    err_exp    = 0;
    stall_prev = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale", ov_snap, 0);
    end

    // First beat after reset lacks in_sof: dropped, then a clean block
    emark = errs_seen;
    send_col(1'b0, make_col(1, 0), tr);
    send_block(1, tr);
    drain();
    check("nosof_err_once", errs_seen - emark, 1);

    // Random backpressure and input gaps
    rand_ready = 1;
    t_mark = rows_seen;
    for (int b = 0; b < 4; b++) begin
      send_block(1, tr);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rand_ready    = 0;
    bus.out_ready = 1'b1;
    check("rand_rows", rows_seen - t_mark, 4 * N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_transpose_buf.md
Name: idct_transpose_buf

Overview:
- Transpose buffer between the first-pass (column) IDCT array and the second-pass (row) IDCT array.
- Accepts one 8-sample column vector per beat, which is the deskewed d_out of the 8 first-pass modules.
- Stores an 8x8 block of 25-bit signed coefficients and emits it row by row as 8 lanes, which feed d_in_1..d_in_8 of the second-pass array.
- Two ping-pong banks let one block fill while the previous block drains.

Parameters:
DW, 25, sample width in bits (signed two's complement)
N, 8, block dimension; lanes per beat and beats per block

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input column beat valid
in_ready  out  1  buffer can accept a column
in_sof  in  1  marks column 0 of a new block
in_col  in  N*DW  column vector; lane k in bits [k*DW +: DW] = row k
out_valid  out  1  output row beat valid
out_ready  in  1  downstream accepts row
out_row  out  N*DW  row vector; lane k = column k
out_eob  out  1  high on the last row (row N-1) of a block
err_sync  out  1  one-cycle pulse on a sync error (below)

Behaviour:
- Reset (reset=0, asynchronous):
  - Both banks go EMPTY; write/read bank pointers = 0; column and row counters = 0.
  - in_ready=0 while reset is asserted, and 1 from the first clk edge after release.
  - out_valid=0, out_row=0, out_eob=0, err_sync=0.
  - Storage contents are don't-care.
  - Reset mid-block discards all partial and full blocks.
- Bank state, per bank: EMPTY -> FILLING (first column accepted) -> FULL (column N-1 accepted) -> DRAINING (first row loaded to output) -> EMPTY (row N-1 accepted by downstream).
- Input handshake: a beat transfers when in_valid && in_ready.
  - in_ready = write bank is EMPTY or FILLING.
  - The column written is the write-bank column counter c: mem[wb][row k][c] <= lane k.
  - On c==N-1 the bank becomes FULL, wb toggles and c resets to 0.
- in_sof rules:
  - Beat with in_sof=1 and c!=0: partial fill discarded, beat stored as column 0, c=1, err_sync pulses next cycle.
  - Beat with in_sof=0 and c==0: beat dropped, err_sync pulses, c stays 0.
- Output: out_row and out_valid are registered.
  - When read bank rb is FULL or DRAINING, the output register is empty or being accepted, and rows remain, load row r next cycle.
  - A row is accepted when out_valid && out_ready; after acceptance of row r, row r+1 loads in the same edge (full throughput).
  - out_eob=1 with row N-1. On its acceptance rb -> EMPTY and rb toggles.
  - While stalled (out_valid && !out_ready), out_row, out_eob and out_valid hold stable.
- Latency: the first row of a block is presented 1 cycle after the edge that accepts column N-1, when the output side is idle.
- Simultaneous events:
  - Last column write to one bank and last row accept from the other in the same cycle are both honoured.
  - in_ready re-asserts the next cycle.
- Both banks FULL/DRAINING: in_ready=0 and no writes occur.
- Steady state: 8 columns in / 8 rows out per 8 cycles, no bubbles when out_ready=1 and in_valid=1.
- Data passes unmodified: no rounding, no saturation, sign preserved.

Decomposition:
- Package idct_pkg:
  - DW, N constants.
  - Bank-state enum {EMPTY, FILLING, FULL, DRAINING}.
  - Lane-slice helper function.
- Sub-module idct_tbuf_bank: one N x N x DW register bank with a column write port and a row read port.
  - Instantiated twice.
  - Top level holds the pointers, counters, bank FSMs and the output register.

Test Plan:
- Reset then a single block, in_col lane k of column c = 100*k + c, out_ready=1:
  - Rows out with lane j of row r = 100*r + j.
  - First out_valid 1 cycle after the 8th accepted column.
  - out_eob only on row 7.
- Back-to-back 3 blocks with in_valid and out_ready held 1:
  - in_ready never drops after the first block.
  - 24 rows out, contiguous, correct transposes.
  - Signed values -1 and -(2^24) round-trip exactly.
- out_ready=0 for 20 cycles while 2 blocks are sent:
  - in_ready falls after the 16th column.
  - out_row stays stable holding row 0.
  - Releasing out_ready drains both blocks in order.
- in_sof asserted on the 4th column of a block:
  - err_sync pulses once.
  - Output block starts with that beat as column 0.
  - Earlier 3 columns are never emitted.
- Assert reset for 1 cycle mid-drain (row 3 of 8):
  - out_valid=0 immediately.
  - No stale rows after release.
  - A fresh block afterwards transposes correctly.
- in_valid with in_sof=0 as the first beat after reset:
  - Beat dropped, err_sync pulses.
  - The following in_sof=1 block is output correctly.
